dpram_port_master: RTL and testbench

Initiator-side driver for one port of the team's true dual-port RAM (`dpram`, data_width 16). It accepts 32-bit word read/write requests with byte enables over a valid/ready handshake and sequences them into 16-bit port cycles. It issues two halfword accesses per word and performs read-modify-write for partial halfword writes, since the RAM port has no byte enables. It returns one response per request. It sits between a CPU/bus model in the test harness and a `dpram` port (`address_x`, `data_x`, `enable_x`, `wren_x`, `cs_x`, `q_x`).

---
 rtl/dpram_port_master.sv | 252 +++++++++++++++++++++++++
 tb/tb_dpram_port_master.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_port_master.sv
// -----------------------------------------------------------------------------
// dpram_port_master
//
// Initiator-side sequencer for one port of the 16-bit true dual-port RAM.
// It takes 32-bit word requests with byte enables and turns them into
// halfword port cycles, always low halfword first, then high. The RAM port has
// no byte enables, so a halfword with only one byte enabled is written with a
// read-modify-write. Each accepted request produces exactly one response pulse.
//
// Ports
//   clock, reset_n         sole clock (rising edge); async active-low reset
//   req_valid / req_ready  request handshake; ready only while idle
//   req_addr               32-bit word address (addr_width bits)
//   req_we                 1 = write, 0 = read
//   req_wdata, req_be      write data (little-endian) and byte enables
//   rsp_valid              one-cycle completion pulse
//   rsp_rdata              read data {hi,lo}; untouched by writes
//   ram_address            halfword address {word, h} to the RAM port
//   ram_data               halfword write data to the RAM port
//   ram_enable, ram_wren   RAM access strobe and write select
//   ram_cs                 RAM chip select; held through capture so q is live
//   ram_q                  RAM read data, valid the cycle after a read issue
// -----------------------------------------------------------------------------
module dpram_port_master #(
    parameter int unsigned addr_width = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [addr_width-1:0] req_addr,
    input  logic                  req_we,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_be,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic [addr_width:0]   ram_address,
    output logic [15:0]           ram_data,
    output logic                  ram_enable,
    output logic                  ram_wren,
    output logic                  ram_cs,
    input  logic [15:0]           ram_q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_RD,
        S_CAPTURE,
        S_WRITE,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_h;
    logic                  w_h_next;

    logic [addr_width-1:0] r_addr;
    logic                  r_we;
    logic [31:0]           r_wdata;
    logic [3:0]            r_be;
    logic [31:0]           r_rdata;
    logic [15:0]           r_ram_data;

    logic                  w_accept;
    logic                  w_we_src;
    logic [3:0]            w_be_src;
    logic [31:0]           w_wdata_src;
    state_t                w_lo_step;
    state_t                w_hi_step;
    logic [15:0]           w_wr_half;
    logic [1:0]            w_be_half;
    logic [15:0]           w_merged;

    // First step needed for one halfword. S_RESP doubles as "nothing to do"
    // so a write with both enables clear for that halfword is skipped.
    function automatic state_t f_first_step(input logic we, input logic [1:0] be_pair);
        state_t s;
        if (!we) begin
            s = S_ISSUE_RD;
        end else if (be_pair == 2'b11) begin
            s = S_WRITE;
        end else if (be_pair == 2'b00) begin
            s = S_RESP;
        end else begin
            s = S_ISSUE_RD;
        end
        return s;
    endfunction

    assign w_accept = (r_state == S_IDLE) && req_valid;

    // Planning looks at the live request while idle (the accept edge decides
    // the first step) and at the registered copy once the request is held.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_we_src    = req_we;
            w_be_src    = req_be;
            w_wdata_src = req_wdata;
        end else begin
            w_we_src    = r_we;
            w_be_src    = r_be;
            w_wdata_src = r_wdata;
        end
        w_lo_step = f_first_step(w_we_src, w_be_src[1:0]);
        w_hi_step = f_first_step(w_we_src, w_be_src[3:2]);
    end

    // Byte merge for read-modify-write of the current halfword.
    always_comb begin
        w_wr_half = r_h ? r_wdata[31:16] : r_wdata[15:0];
        w_be_half = r_h ? r_be[3:2] : r_be[1:0];
        w_merged  = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            w_merged[8*k +: 8] = w_be_half[k] ? w_wr_half[8*k +: 8] : ram_q[8*k +: 8];
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_h     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_h     <= w_h_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next   = r_state;
        w_h_next = r_h;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_lo_step != S_RESP) begin
                        w_next   = w_lo_step;
                        w_h_next = 1'b0;
                    end else begin
                        // lo skipped: go to hi's first step, or straight to
                        // RESP when the write has no byte enables at all.
                        w_next   = w_hi_step;
                        w_h_next = 1'b1;
                    end
                end
            end
            S_ISSUE_RD: begin
                w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (r_we) begin
                    w_next = S_WRITE;
                end else if (!r_h && (w_hi_step != S_RESP)) begin
                    w_next   = w_hi_step;
                    w_h_next = 1'b1;
                end else begin
                    w_next = S_RESP;
                end
            end
            S_WRITE: begin
                if (!r_h && (w_hi_step != S_RESP)) begin
                    w_next   = w_hi_step;
                    w_h_next = 1'b1;
                end else begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Output decode: strobes come from state only.
    always_comb begin
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        ram_enable = 1'b0;
        ram_wren   = 1'b0;
        ram_cs     = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
            end
            S_ISSUE_RD: begin
                ram_enable = 1'b1;
                ram_cs     = 1'b1;
            end
            S_CAPTURE: begin
                ram_cs = 1'b1;
            end
            S_WRITE: begin
                ram_enable = 1'b1;
                ram_cs     = 1'b1;
                ram_wren   = 1'b1;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // Request capture, read-data capture and halfword write buffer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_rdata    <= '0;
            r_ram_data <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr;
                r_we    <= req_we;
                r_wdata <= req_wdata;
                r_be    <= req_be;
            end
            if ((r_state == S_CAPTURE) && !r_we) begin
                if (r_h) begin
                    r_rdata[31:16] <= ram_q;
                end else begin
                    r_rdata[15:0] <= ram_q;
                end
            end
            // Loaded on the edge entering WRITE so ram_data is already a
            // register output during the write cycle.
            if (w_next == S_WRITE) begin
                if (r_state == S_CAPTURE) begin
                    r_ram_data <= w_merged;
                end else if (w_h_next) begin
                    r_ram_data <= w_wdata_src[31:16];
                end else begin
                    r_ram_data <= w_wdata_src[15:0];
                end
            end
        end
    end

    // Address is {word, h}; both are registers, so it holds while idle.
    assign ram_address = {r_addr, r_h};
    assign ram_data    = r_ram_data;
    assign rsp_rdata   = r_rdata;

endmodule

// File: tb/tb_dpram_port_master.sv
// -----------------------------------------------------------------------------
// tb_dpram_port_master
//
// Bench for dpram_port_master. A behavioural 16-bit RAM port sits on the RAM
// side; a word-level reference memory with byte-enable merge predicts every
// response. Requests push expectations (data, latency, port activity) into a
// scoreboard queue; a monitor pops and compares on each rsp_valid.
// -----------------------------------------------------------------------------
module tb_dpram_port_master;

    localparam int unsigned AW = 8;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_we;
    logic [31:0]   req_wdata;
    logic [3:0]    req_be;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic [AW:0]   ram_address;
    logic [15:0]   ram_data;
    logic          ram_enable;
    logic          ram_wren;
    logic          ram_cs;
    logic [15:0]   ram_q;

    dpram_port_master #(.addr_width(AW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_we      (req_we),
        .req_wdata   (req_wdata),
        .req_be      (req_be),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_enable  (ram_enable),
        .ram_wren    (ram_wren),
        .ram_cs      (ram_cs),
        .ram_q       (ram_q)
    );

    always #5 clock = ~clock;

    // RAM port: synchronous read, q forced to all-ones when not selected.
    logic [15:0] ram_mem [0:(1<<(AW+1))-1];
    logic [15:0] ram_qr;
    always @(posedge clock) begin
        if (ram_enable && ram_cs) begin
            if (ram_wren) ram_mem[ram_address] <= ram_data;
            else          ram_qr <= ram_mem[ram_address];
        end
    end
    assign ram_q = ram_cs ? ram_qr : 16'hFFFF;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference word memory and scoreboard
    logic [31:0] mdl [0:(1<<AW)-1];
    logic [31:0] exp_last_rd = '0;

    typedef struct {
        logic [31:0] rdata;
        int unsigned acc;
        int unsigned lat;
        int unsigned cs_n;
        int unsigned en_n;
        int unsigned wr_n;
        int unsigned gap;
    } exp_t;
    exp_t sbq[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Issue one request; returns on the negedge before the accept edge with
    // req_valid still high so callers can chain requests back to back.
    task automatic do_req(input logic [AW-1:0] a, input logic we, input logic [31:0] wd,
                          input logic [3:0] be, input int unsigned gap);
        exp_t        e;
        int unsigned guard;
        logic [1:0]  pair;
        @(negedge clock);
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = we;
        req_wdata = wd;
        req_be    = be;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: actual=ready_low required=ready_high");
            req_valid = 1'b0;
            return;
        end
        e.acc = cyc;
        e.gap = gap;
        if (!we) begin
            e.rdata     = mdl[a];
            exp_last_rd = mdl[a];
            e.lat  = 5;
            e.en_n = 2;
            e.wr_n = 0;
        end else begin
            e.rdata = exp_last_rd;
            e.lat   = 1;
            e.en_n  = 0;
            e.wr_n  = 0;
            for (int n = 0; n < 4; n++) begin
                if (be[n]) mdl[a][8*n +: 8] = wd[8*n +: 8];
            end
            for (int hh = 0; hh < 2; hh++) begin
                pair = be[2*hh +: 2];
                if (pair == 2'b11) begin
                    e.lat += 1; e.en_n += 1; e.wr_n += 1;
                end else if (pair != 2'b00) begin
                    e.lat += 3; e.en_n += 2; e.wr_n += 1;
                end
            end
        end
        e.cs_n = e.lat - 1;
        sbq.push_back(e);
    endtask

    task automatic drain();
        int unsigned g = 0;
        while (sbq.size() != 0 && g < 200) begin
            @(negedge clock);
            g++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: actual=%0d pending required=0 pending", sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic single(input logic [AW-1:0] a, input logic we, input logic [31:0] wd,
                          input logic [3:0] be);
        do_req(a, we, wd, be, 0);
        @(negedge clock);
        req_valid = 1'b0;
        drain();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"},   32'(req_ready),   32'd1);
        chk({tag, "_rsp_valid"},   32'(rsp_valid),   32'd0);
        chk({tag, "_rsp_rdata"},   rsp_rdata,        32'd0);
        chk({tag, "_ram_address"}, 32'(ram_address), 32'd0);
        chk({tag, "_ram_data"},    32'(ram_data),    32'd0);
        chk({tag, "_ram_enable"},  32'(ram_enable),  32'd0);
        chk({tag, "_ram_wren"},    32'(ram_wren),    32'd0);
        chk({tag, "_ram_cs"},      32'(ram_cs),      32'd0);
    endtask

    // Monitor: port activity is counted per request between responses.
    int unsigned n_cs = 0, n_en = 0, n_wr = 0, last_rsp = 0;
    exp_t m_e;
    always @(negedge clock) begin
        if (!reset_n) begin
            n_cs = 0; n_en = 0; n_wr = 0;
        end else begin
            if (ram_cs)     n_cs++;
            if (ram_enable) n_en++;
            if (ram_wren)   n_wr++;
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: actual=rsp_valid required=no_response");
                end else begin
                    m_e = sbq.pop_front();
                    chk("rsp_rdata",      rsp_rdata,       m_e.rdata);
                    chk("rsp_latency",    32'(cyc - m_e.acc), 32'(m_e.lat));
                    chk("ram_cs_cycles",  32'(n_cs),       32'(m_e.cs_n));
                    chk("ram_en_cycles",  32'(n_en),       32'(m_e.en_n));
                    chk("ram_wren_cycles",32'(n_wr),       32'(m_e.wr_n));
                    if (m_e.gap != 0) chk("rsp_spacing", 32'(cyc - last_rsp), 32'(m_e.gap));
                end
                last_rsp = cyc;
                n_cs = 0; n_en = 0; n_wr = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0]   w;
        int unsigned   guard;
        logic [AW-1:0] ra;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_we    = 1'b0;
        req_wdata = '0;
        req_be    = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            w = $urandom;
            mdl[i]         = w;
            ram_mem[2*i]   = w[15:0];
            ram_mem[2*i+1] = w[31:16];
        end
        #1;
        chk_reset_outputs("reset");
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;

        // Full-word write lands in both halfwords, then reads back.
        single(8'd5, 1'b1, 32'h11223344, 4'hF);
        chk("ram_hw10", 32'(ram_mem[10]), 32'h0000_3344);
        chk("ram_hw11", 32'(ram_mem[11]), 32'h0000_1122);
        single(8'd5, 1'b0, 32'h0, 4'h0);

        // Single-byte RMW
        single(8'd2, 1'b1, 32'hAABBCCDD, 4'hF);
        single(8'd2, 1'b1, 32'h00000055, 4'h1);
        single(8'd2, 1'b0, 32'h0, 4'h0);
        chk("ref_word2", mdl[2], 32'hAABBCC55);

        // No byte enables: response only
        single(8'd7, 1'b1, $urandom, 4'h0);

        // Two RMWs
        single(8'd9, 1'b1, 32'hFFFFFFFF, 4'hF);
        single(8'd9, 1'b1, 32'h12345678, 4'hA);
        single(8'd9, 1'b0, 32'h0, 4'h0);
        chk("ref_word9", mdl[9], 32'h12FF56FF);

        // Other halfword patterns
        single(8'd11, 1'b1, 32'hCAFEBABE, 4'h3);
        single(8'd11, 1'b1, 32'h5A5A5A5A, 4'hC);
        single(8'd11, 1'b1, 32'h01020304, 4'h5);
        single(8'd11, 1'b0, 32'h0, 4'h0);

        // Three queued reads with req_valid held high
        do_req(8'd1, 1'b0, 32'h0, 4'h0, 0);
        do_req(8'd4, 1'b0, 32'h0, 4'h0, 6);
        do_req(8'd6, 1'b0, 32'h0, 4'h0, 6);
        @(negedge clock);
        req_valid = 1'b0;
        drain();

        // Reset during CAPTURE of a read
        do_req(8'd3, 1'b0, 32'h0, 4'h0, 0);
        @(negedge clock);
        req_valid = 1'b0;
        guard = 0;
        while (!(ram_cs && !ram_enable) && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        chk("reached_capture", 32'(ram_cs && !ram_enable), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk_reset_outputs("midop_reset");
        sbq.delete();
        exp_last_rd = '0;
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        repeat (8) @(negedge clock);
        single(8'd3, 1'b0, 32'h0, 4'h0);

        // Random traffic over a small address window
        for (int t = 0; t < 40; t++) begin
            ra = AW'($urandom_range(15, 0));
            do_req(ra, 1'($urandom), $urandom, 4'($urandom), 0);
            if ($urandom_range(1, 0) == 1) begin
                @(negedge clock);
                req_valid = 1'b0;
                repeat ($urandom_range(2, 0)) @(negedge clock);
            end
        end
        @(negedge clock);
        req_valid = 1'b0;
        drain();
        for (int i = 0; i < 16; i++) begin
            chk("final_word", {ram_mem[2*i+1], ram_mem[2*i]}, mdl[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
